// File: rtl/spot_allocator.sv
// Eight-spot parking allocator: serves one entry or exit request at a time, exit first, then holds the barrier open.
// Latency: responses are registered pulses one cycle after sampling. Backpressure: requests are level-held and ignored until the served one drops.
module spot_allocator #(
    parameter int GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_spot,
    output logic       entry_ack,
    output logic [2:0] entry_spot,
    output logic       entry_deny,
    output logic       exit_ack,
    output logic       exit_err,
    output logic       gate_open,
    output logic [7:0] new_capacity,
    output logic       full
);
    localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES);

    typedef enum logic [1:0] {IDLE, GATE, WAIT_LOW} state_t;

    state_t     state_q, state_d;
    logic [7:0] occ_q, occ_d;
    logic [2:0] spot_q, spot_d;
    logic [3:0] timer_q, timer_d;
    logic       gate_q, gate_d;
    logic       served_exit_q, served_exit_d;
    logic       entry_ack_q, entry_ack_d;
    logic       entry_deny_q, entry_deny_d;
    logic       exit_ack_q, exit_ack_d;
    logic       exit_err_q, exit_err_d;
    logic [2:0] free_idx;
    logic       lot_full;

    assign lot_full = (occ_q == 8'hFF);

    // Descending scan so the last assignment wins with the lowest free index.
    always_comb begin
        free_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!occ_q[i]) free_idx = 3'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        occ_d         = occ_q;
        spot_d        = spot_q;
        timer_d       = timer_q;
        gate_d        = 1'b0;
        served_exit_d = served_exit_q;
        entry_ack_d   = 1'b0;
        entry_deny_d  = 1'b0;
        exit_ack_d    = 1'b0;
        exit_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (exit_req) begin
                    served_exit_d = 1'b1;
                    if (occ_q[exit_spot]) begin
                        occ_d[exit_spot] = 1'b0;
                        exit_ack_d       = 1'b1;
                        timer_d          = GATE_LOAD;
                        state_d          = GATE;
                    end else begin
                        exit_err_d = 1'b1;
                        state_d    = WAIT_LOW;
                    end
                end else if (entry_req) begin
                    served_exit_d = 1'b0;
                    if (!lot_full) begin
                        occ_d[free_idx] = 1'b1;
                        spot_d          = free_idx;
                        entry_ack_d     = 1'b1;
                        timer_d         = GATE_LOAD;
                        state_d         = GATE;
                    end else begin
                        entry_deny_d = 1'b1;
                        state_d      = WAIT_LOW;
                    end
                end
            end
            GATE: begin
                // Timer only counts down while nonzero, so it can never wrap.
                if (timer_q != 4'd0) begin
                    gate_d  = 1'b1;
                    timer_d = timer_q - 4'd1;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!(served_exit_q ? exit_req : entry_req)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            occ_q         <= 8'h00;
            spot_q        <= 3'd0;
            timer_q       <= 4'd0;
            gate_q        <= 1'b0;
            served_exit_q <= 1'b0;
            entry_ack_q   <= 1'b0;
            entry_deny_q  <= 1'b0;
            exit_ack_q    <= 1'b0;
            exit_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            occ_q         <= occ_d;
            spot_q        <= spot_d;
            timer_q       <= timer_d;
            gate_q        <= gate_d;
            served_exit_q <= served_exit_d;
            entry_ack_q   <= entry_ack_d;
            entry_deny_q  <= entry_deny_d;
            exit_ack_q    <= exit_ack_d;
            exit_err_q    <= exit_err_d;
        end
    end

    assign entry_ack    = entry_ack_q;
    assign entry_spot   = spot_q;
    assign entry_deny   = entry_deny_q;
    assign exit_ack     = exit_ack_q;
    assign exit_err     = exit_err_q;
    assign gate_open    = gate_q;
    assign new_capacity = occ_q;
    assign full         = lot_full;

endmodule

// File: tb/tb_spot_allocator.sv
// Bench for spot_allocator: vector table, hand-written corner sequences and a randomized run against a transaction-level model.
// Checks are sampled on the falling clock edge; inputs change 1 time unit after the rising edge.
module tb_spot_allocator;
    localparam int GC = 4;
    localparam logic [3:0] R_EACK = 4'b1000;
    localparam logic [3:0] R_DENY = 4'b0100;
    localparam logic [3:0] R_XACK = 4'b0010;
    localparam logic [3:0] R_XERR = 4'b0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_spot = 3'd0;
    logic       entry_ack, entry_deny, exit_ack, exit_err, gate_open, full;
    logic [2:0] entry_spot;
    logic [7:0] new_capacity;
    logic [3:0] resp;

    int         n_checks = 0;
    int         n_fail = 0;
    bit         occ [8];
    logic [2:0] held_spot = 3'd0;

    typedef struct {
        bit         is_exit;
        logic [2:0] spot;
        logic [3:0] resp;
        logic [2:0] exp_spot;
        logic [7:0] cap;
    } vec_t;
    vec_t tbl [16];

    spot_allocator #(.GATE_CYCLES(GC)) dut (
        .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req), .exit_spot(exit_spot),
        .entry_ack(entry_ack), .entry_spot(entry_spot), .entry_deny(entry_deny), .exit_ack(exit_ack),
        .exit_err(exit_err), .gate_open(gate_open), .new_capacity(new_capacity), .full(full)
    );

    always #5 clk = ~clk;
    assign resp = {entry_ack, entry_deny, exit_ack, exit_err};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) check("one_pulse", 32'($countones(resp) <= 1), 32'd1);

    // Spec-level rules: exit frees an occupied spot or errors; entry takes the lowest free spot or is denied.
    task automatic model(input bit ex, input logic [2:0] sp, output logic [3:0] r,
                         output logic [2:0] s, output logic [7:0] c);
        int first_free;
        first_free = -1;
        s = held_spot;
        if (ex) begin
            if (occ[sp]) begin occ[sp] = 1'b0; r = R_XACK; end
            else r = R_XERR;
        end else begin
            for (int i = 0; i < 8; i++) if (!occ[i] && first_free < 0) first_free = i;
            if (first_free < 0) r = R_DENY;
            else begin occ[first_free] = 1'b1; r = R_EACK; s = 3'(first_free); end
        end
        c = 8'd0;
        for (int i = 0; i < 8; i++) if (occ[i]) c = c + 8'(1 << i);
    endtask

    task automatic check_gate_window(input bit grant);
        for (int k = 0; k < GC + 2; k++) begin
            @(negedge clk);
            check("gate_open", 32'(gate_open), 32'(grant && (k < GC)));
            check("no_repeat", 32'(resp), 32'd0);
        end
    endtask

    task automatic transact(input bit ex, input logic [2:0] sp, input logic [3:0] exp_resp,
                            input logic [2:0] exp_spot, input logic [7:0] exp_cap);
        @(posedge clk); #1;
        if (ex) begin exit_req = 1'b1; exit_spot = sp; end
        else entry_req = 1'b1;
        @(negedge clk);
        check("pre_resp", 32'(resp), 32'd0);
        @(negedge clk);
        check("resp", 32'(resp), 32'(exp_resp));
        check("capacity", 32'(new_capacity), 32'(exp_cap));
        check("full", 32'(full), 32'(exp_cap == 8'hFF));
        if (exp_resp == R_EACK) held_spot = exp_spot;
        check("entry_spot", 32'(entry_spot), 32'(held_spot));
        check_gate_window(exp_resp == R_EACK || exp_resp == R_XACK);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp", 32'(resp), 32'd0);
        check("rst_cap", 32'(new_capacity), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_gate", 32'(gate_open), 32'd0);
        check("rst_spot", 32'(entry_spot), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        held_spot = 3'd0;
        for (int i = 0; i < 8; i++) occ[i] = 1'b0;
    endtask

    initial begin
        bit         ex, got;
        logic [2:0] sp, s;
        logic [3:0] r;
        logic [7:0] c, init_occ;

        for (int i = 0; i < 8; i++) tbl[i] = '{1'b0, 3'd0, R_EACK, 3'(i), 8'((1 << (i + 1)) - 1)};
        tbl[8]  = '{1'b0, 3'd0, R_DENY, 3'd0, 8'hFF};
        tbl[9]  = '{1'b1, 3'd3, R_XACK, 3'd0, 8'hF7};
        tbl[10] = '{1'b0, 3'd0, R_EACK, 3'd3, 8'hFF};
        tbl[11] = '{1'b1, 3'd7, R_XACK, 3'd0, 8'h7F};
        tbl[12] = '{1'b1, 3'd7, R_XERR, 3'd0, 8'h7F};
        tbl[13] = '{1'b1, 3'd0, R_XACK, 3'd0, 8'h7E};
        tbl[14] = '{1'b0, 3'd0, R_EACK, 3'd0, 8'h7F};
        tbl[15] = '{1'b0, 3'd0, R_EACK, 3'd7, 8'hFF};

        do_reset();
        for (int i = 0; i < 16; i++)
            transact(tbl[i].is_exit, tbl[i].spot, tbl[i].resp, tbl[i].exp_spot, tbl[i].cap);

        // Simultaneous entry and exit on a full lot: exit wins, entry then reuses the freed spot.
        @(posedge clk); #1;
        entry_req = 1'b1; exit_req = 1'b1; exit_spot = 3'd5;
        @(negedge clk);
        check("simul_pre", 32'(resp), 32'd0);
        @(negedge clk);
        check("simul_exit", 32'(resp), 32'(R_XACK));
        check("simul_cap1", 32'(new_capacity), 32'hDF);
        check("simul_full1", 32'(full), 32'd0);
        check_gate_window(1'b1);
        exit_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (resp != 4'd0) got = 1'b1;
        end
        check("simul_entry_served", 32'(got), 32'd1);
        check("simul_entry", 32'(resp), 32'(R_EACK));
        check("simul_spot", 32'(entry_spot), 32'd5);
        check("simul_cap2", 32'(new_capacity), 32'hFF);
        check_gate_window(1'b1);
        entry_req = 1'b0;
        repeat (2) @(posedge clk);

        do_reset();
        transact(1'b1, 3'd2, R_XERR, 3'd0, 8'h00);

        // Reset in the second GATE cycle aborts the grant; the still-held request is served afresh.
        @(posedge clk); #1;
        entry_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_ack", 32'(resp), 32'(R_EACK));
        check("abort_cap", 32'(new_capacity), 32'h01);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_gate", 32'(gate_open), 32'd0);
        check("abort_cap0", 32'(new_capacity), 32'h00);
        check("abort_resp", 32'(resp), 32'd0);
        check("abort_spot", 32'(entry_spot), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("held_pre", 32'(resp), 32'd0);
        @(negedge clk);
        check("held_ack", 32'(resp), 32'(R_EACK));
        check("held_spot", 32'(entry_spot), 32'd0);
        check("held_cap", 32'(new_capacity), 32'h01);
        check_gate_window(1'b1);
        entry_req = 1'b0;
        repeat (2) @(posedge clk);

        init_occ = 8'h01;
        for (int i = 0; i < 8; i++) occ[i] = init_occ[i];
        held_spot = 3'd0;
        for (int n = 0; n < 200; n++) begin
            ex = ($urandom_range(0, 99) < 45);
            sp = 3'($urandom_range(0, 7));
            model(ex, sp, r, s, c);
            transact(ex, sp, r, s, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spot_allocator.md
SPOT_ALLOCATOR -- requirements
Module: spot_allocator

Interface
REQ-001 Parameter GATE_CYCLES, default 4, SHALL set the number of cycles gate_open is held per granted entry or exit, legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 entry_req  input  1  SHALL be a level request from the entry sensor, held until entry_ack or entry_deny.
REQ-005 exit_req  input  1  SHALL be a level request from the exit sensor, held until exit_ack or exit_err.
REQ-006 exit_spot  input  3  SHALL be the index of the spot being vacated, valid while exit_req=1.
REQ-007 entry_ack  output  1  SHALL be a one-cycle pulse granting entry.
REQ-008 entry_spot  output  3  SHALL be the allocated spot index, valid in the entry_ack cycle and held until the next grant.
REQ-009 entry_deny  output  1  SHALL be a one-cycle pulse refusing entry because the lot is full.
REQ-010 exit_ack  output  1  SHALL be a one-cycle pulse confirming release of exit_spot.
REQ-011 exit_err  output  1  SHALL be a one-cycle pulse flagging an exit for a spot that is already free.
REQ-012 gate_open  output  1  SHALL drive the barrier; 1 means open.
REQ-013 new_capacity  output  8  SHALL be the occupancy vector: bit i=1 means spot i is occupied; it feeds the ones counter directly.
REQ-014 full  output  1  SHALL be 1 exactly when new_capacity==8'hFF.

Function
REQ-015 The FSM SHALL have three states: IDLE, GATE and WAIT_LOW.
REQ-016 In IDLE, requests SHALL be sampled on each rising edge; every response SHALL appear as a registered pulse one cycle after sampling, with no combinational path from input to output.
REQ-017 When exit_req and entry_req are both 1 in IDLE, exit SHALL be served first; entry SHALL remain pending and be served on the next return to IDLE.
REQ-018 Exit when new_capacity[exit_spot]=1: the bit SHALL be cleared, exit_ack SHALL pulse, and the next state SHALL be GATE.
REQ-019 Exit when new_capacity[exit_spot]=0: occupancy SHALL be unchanged, exit_err SHALL pulse, and the next state SHALL be WAIT_LOW.
REQ-020 Entry with full=0: the lowest-index free spot SHALL be set, entry_spot SHALL take that index, entry_ack SHALL pulse, and the next state SHALL be GATE.
REQ-021 Entry with full=1: occupancy SHALL be unchanged, entry_deny SHALL pulse, and the next state SHALL be WAIT_LOW.
REQ-022 The new_capacity and full updates SHALL become visible in the same cycle as the corresponding ack pulse.
REQ-023 GATE: gate_open SHALL be 1 for exactly GATE_CYCLES consecutive cycles, starting the cycle after the ack pulse; requests SHALL be ignored; the next state SHALL then be WAIT_LOW.
REQ-024 WAIT_LOW: the FSM SHALL return to IDLE on the first edge where the request that was just served is 0; any other pending request SHALL stay pending.
REQ-025 No request SHALL produce more than one response pulse.
REQ-026 At most one of entry_ack, entry_deny, exit_ack and exit_err SHALL be 1 in any cycle.
REQ-027 An entry when exactly one spot is free SHALL take that spot and set full=1 in the entry_ack cycle.
REQ-028 The gate timer SHALL be 4 bits wide and SHALL saturate at zero; it SHALL never wrap.

Reset
REQ-029 With rst=1 at an edge, the FSM SHALL go to IDLE, new_capacity=8'h00, full=0, entry_spot=0, gate_open=0, all pulse outputs=0, and the timer=0.
REQ-030 A reset during GATE or WAIT_LOW SHALL abort the operation immediately; the aborted operation SHALL NOT be acknowledged after reset.
REQ-031 Requests still held when rst falls SHALL be served normally from IDLE.

Verification
REQ-032 After reset, 8 sequential entries -> entry_spot 0,1,...,7; new_capacity 01,03,...,FF; full=1 after the 8th; each gate_open high 4 cycles.
REQ-033 Lot full, then entry_req -> single entry_deny pulse, no gate_open, new_capacity stays FF; deny does not repeat while entry_req is held.
REQ-034 new_capacity=FF, exit_spot=3 -> exit_ack, new_capacity=F7, full=0; the next entry gets entry_spot=3 and new_capacity=FF.
REQ-035 entry_req and exit_req (exit_spot=5, occupied) rise in the same cycle with a full lot -> exit_ack first; after GATE and WAIT_LOW, entry_ack with entry_spot=5.
REQ-036 new_capacity=00, exit_spot=2 -> exit_err pulse, no gate_open, new_capacity stays 00.
REQ-037 rst asserted in the 2nd GATE cycle -> next cycle gate_open=0, new_capacity=00, state IDLE, no pending pulse.
